// File: rtl/wts_channel_scheduler.sv
// Wave-RAM scheduler for a five-channel wavetable tone generator: rotates channel
// slots, issues tone fetches, and slots CPU reads/writes into the free cycles.
module wts_channel_scheduler (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [2:0] active,
    output logic       address_reset,
    input  logic [6:0] wave_address,
    input  logic [4:0] key_restart,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [9:0] cpu_address,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_ack,
    output logic [9:0] ram_address,
    output logic       ram_we,
    output logic       ram_re,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic [7:0] sample,
    output logic [2:0] sample_channel,
    output logic       sample_valid
);

    localparam logic [2:0] CPU_SLOT = 3'd5;

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, GUARD} cpu_state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_TONE, SRC_CPU} src_t;

    cpu_state_t state, state_nxt;
    src_t       tag1_src, tag2_src;
    logic [2:0] tag1_ch, tag2_ch;
    logic [4:0] pending, slot_clear;
    logic       tone_fetch, cpu_valid_ch, grant_wr, grant_rd;

    assign tone_fetch   = enable && (active < CPU_SLOT);
    assign cpu_valid_ch = cpu_address[9:7] < CPU_SLOT;

    always_ff @(posedge clk) begin
        if (reset)
            active <= '0;
        else if (enable)
            active <= (active == CPU_SLOT) ? 3'd0 : active + 3'd1;
    end

    always_comb begin
        slot_clear = '0;
        if (tone_fetch)
            slot_clear[active] = 1'b1;
    end

    // A restart arriving on the clearing edge wins, so it survives to the next round.
    always_ff @(posedge clk) begin
        if (reset)
            pending <= '0;
        else
            pending <= (pending & ~slot_clear) | key_restart;
    end

    always_comb begin
        address_reset = 1'b0;
        if (active < CPU_SLOT)
            address_reset = pending[active];
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (grant_wr) state_nxt = GUARD;
                      else if (grant_rd) state_nxt = RD_ISSUE;
            RD_ISSUE: state_nxt = RD_WAIT;
            RD_WAIT:  state_nxt = GUARD;
            GUARD:    state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state == IDLE && !tone_fetch && cpu_req) begin
            grant_wr = cpu_we;
            grant_rd = !cpu_we;
        end
    end

    // Read tags travel with the data two cycles behind the issue, independent of the slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_we         <= 1'b0;
            ram_re         <= 1'b0;
            ram_address    <= '0;
            ram_wdata      <= '0;
            cpu_ack        <= 1'b0;
            cpu_rdata      <= '0;
            sample         <= '0;
            sample_channel <= '0;
            sample_valid   <= 1'b0;
            tag1_src       <= SRC_NONE;
            tag1_ch        <= '0;
            tag2_src       <= SRC_NONE;
            tag2_ch        <= '0;
        end else begin
            ram_we       <= 1'b0;
            ram_re       <= 1'b0;
            cpu_ack      <= 1'b0;
            sample_valid <= 1'b0;
            tag1_src     <= SRC_NONE;
            if (tone_fetch) begin
                ram_re      <= 1'b1;
                ram_address <= {active, wave_address};
                tag1_src    <= SRC_TONE;
                tag1_ch     <= active;
            end else if (grant_wr) begin
                cpu_ack <= 1'b1;
                if (cpu_valid_ch) begin
                    ram_we      <= 1'b1;
                    ram_address <= cpu_address;
                    ram_wdata   <= cpu_wdata;
                end
            end else if (grant_rd && cpu_valid_ch) begin
                ram_re      <= 1'b1;
                ram_address <= cpu_address;
                tag1_src    <= SRC_CPU;
                tag1_ch     <= cpu_address[9:7];
            end
            tag2_src <= tag1_src;
            tag2_ch  <= tag1_ch;
            if (tag2_src == SRC_TONE) begin
                sample         <= ram_rdata;
                sample_channel <= tag2_ch;
                sample_valid   <= 1'b1;
            end
            if (state == RD_WAIT) begin
                cpu_ack   <= 1'b1;
                cpu_rdata <= (tag2_src == SRC_CPU) ? ram_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_wts_channel_scheduler.sv
// Randomized bench for wts_channel_scheduler: a cycle-scheduled reference model
// predicts every registered output; a RAM model answers the DUT's reads.
module tb_wts_channel_scheduler;

    logic       clk = 1'b0;
    logic       reset, enable, address_reset;
    logic [2:0] active;
    logic [6:0] wave_address;
    logic [4:0] key_restart;
    logic       cpu_req, cpu_we, cpu_ack;
    logic [9:0] cpu_address;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic [9:0] ram_address;
    logic       ram_we, ram_re;
    logic [7:0] ram_wdata, ram_rdata;
    logic [7:0] sample;
    logic [2:0] sample_channel;
    logic       sample_valid;

    always #5 clk = ~clk;

    wts_channel_scheduler dut (
        .clk(clk), .reset(reset), .enable(enable), .active(active),
        .address_reset(address_reset), .wave_address(wave_address),
        .key_restart(key_restart), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack), .ram_address(ram_address), .ram_we(ram_we),
        .ram_re(ram_re), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .sample(sample), .sample_channel(sample_channel), .sample_valid(sample_valid)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Expected outputs scheduled by absolute cycle, indexed modulo 8.
    bit         e_re[8], e_we[8], e_ack[8], e_rdchk[8], e_sv[8], e_zero[8];
    logic [9:0] e_addr[8];
    logic [7:0] e_wdata[8], e_rdata[8], e_sample[8];
    logic [2:0] e_sch[8];

    logic [7:0] model_mem[1024];
    logic [7:0] env_mem[1024];
    bit         env_rd_v;
    logic [9:0] env_rd_a;
    int         m_active, idle_at;
    bit [4:0]   m_pend;
    bit         drop_next, ack_now;

    task automatic clear_slot(input int s);
        e_re[s] = 0; e_we[s] = 0; e_ack[s] = 0; e_rdchk[s] = 0; e_sv[s] = 0; e_zero[s] = 0;
    endtask

    task automatic model_step();
        int s1, s3;
        logic [9:0] a;
        bit ok;
        s1 = (cyc + 1) % 8;
        s3 = (cyc + 3) % 8;
        if (reset) begin
            for (int i = 0; i < 8; i++) clear_slot(i);
            e_zero[s1] = 1;
            m_active = 0;
            m_pend = '0;
            idle_at = cyc + 1;
            return;
        end
        if (enable && m_active < 5) begin
            a = {3'(m_active), wave_address};
            e_re[s1] = 1; e_addr[s1] = a;
            e_sv[s3] = 1; e_sample[s3] = model_mem[a]; e_sch[s3] = 3'(m_active);
        end else if (cpu_req && cyc >= idle_at) begin
            ok = cpu_address[9:7] < 3'd5;
            if (cpu_we) begin
                e_ack[s1] = 1;
                if (ok) begin
                    e_we[s1] = 1; e_addr[s1] = cpu_address; e_wdata[s1] = cpu_wdata;
                    model_mem[cpu_address] = cpu_wdata;
                end
                idle_at = cyc + 2;
            end else begin
                if (ok) begin e_re[s1] = 1; e_addr[s1] = cpu_address; end
                e_ack[s3] = 1; e_rdchk[s3] = 1;
                e_rdata[s3] = ok ? model_mem[cpu_address] : 8'h00;
                idle_at = cyc + 4;
            end
        end
        for (int k = 0; k < 5; k++)
            if (enable && m_active == k) m_pend[k] = 1'b0;
        m_pend |= key_restart;
        if (enable) m_active = (m_active + 1) % 6;
    endtask

    initial begin
        int s;
        for (int i = 0; i < 1024; i++) begin
            model_mem[i] = 8'($urandom);
            env_mem[i]   = model_mem[i];
        end
        reset = 1'b1; enable = 1'b0; key_restart = '0; wave_address = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_address = '0; cpu_wdata = '0; ram_rdata = '0;
        env_rd_v = 0; env_rd_a = '0; drop_next = 0;
        for (int i = 0; i < 8; i++) clear_slot(i);
        @(posedge clk); #1;
        m_active = 0; m_pend = '0; idle_at = 0; e_zero[0] = 1;

        for (cyc = 0; cyc < 4000; cyc++) begin
            s = cyc % 8;
            check("active", 32'(active), 32'(m_active));
            check("address_reset", 32'(address_reset),
                  32'((m_active < 5) ? m_pend[m_active] : 1'b0));
            check("ram_re", 32'(ram_re), 32'(e_re[s]));
            check("ram_we", 32'(ram_we), 32'(e_we[s]));
            check("cpu_ack", 32'(cpu_ack), 32'(e_ack[s]));
            check("sample_valid", 32'(sample_valid), 32'(e_sv[s]));
            if (e_re[s] || e_we[s]) check("ram_address", 32'(ram_address), 32'(e_addr[s]));
            if (e_we[s]) check("ram_wdata", 32'(ram_wdata), 32'(e_wdata[s]));
            if (e_rdchk[s]) check("cpu_rdata", 32'(cpu_rdata), 32'(e_rdata[s]));
            if (e_sv[s]) begin
                check("sample", 32'(sample), 32'(e_sample[s]));
                check("sample_channel", 32'(sample_channel), 32'(e_sch[s]));
            end
            if (e_zero[s]) begin
                check("rst_ram_address", 32'(ram_address), 32'(0));
                check("rst_ram_wdata", 32'(ram_wdata), 32'(0));
                check("rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
                check("rst_sample", 32'(sample), 32'(0));
                check("rst_sample_channel", 32'(sample_channel), 32'(0));
            end
            ack_now = e_ack[s];
            clear_slot(s);

            ram_rdata = env_rd_v ? env_mem[env_rd_a] : 8'($urandom);
            if (ram_we === 1'b1) env_mem[ram_address] = ram_wdata;
            env_rd_v = (ram_re === 1'b1);
            env_rd_a = ram_address;

            // Master holds the request through the ack cycle, drops it the cycle after.
            if (drop_next) begin cpu_req = 1'b0; drop_next = 0; end
            if (!cpu_req && $urandom_range(0, 3) == 0) begin
                cpu_req = 1'b1;
                cpu_we = 1'($urandom);
                cpu_address = 10'($urandom);
                cpu_wdata = 8'($urandom);
            end
            if (ack_now) drop_next = 1;

            reset        = ($urandom_range(0, 59) == 0);
            enable       = ($urandom_range(0, 3) != 0);
            key_restart  = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
            wave_address = 7'($urandom);

            model_step();
            @(posedge clk); #1;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
